// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, FSM states and flag bit positions shared by the sequential ALU
package ula_pkg;
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_NOT  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_PASS = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_SAR  = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_MULH = 4'hB;
   localparam logic [3:0] OP_CMP  = 4'hC;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   typedef enum logic [1:0] {OCIOSO, EXECUTA, FIM} state_t;
endpackage

// File: rtl/ula_mul_seq.sv
// ula_mul_seq: WIDTH-cycle unsigned shift-add multiplier, one-cycle done pulse when the product is ready
module ula_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product,
   output logic               done
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     sum;
   // multiplier bits sit in the low half and are consumed LSB first while partial sums enter the top
   always_comb begin
      sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
      acc_d  = start ? {{WIDTH{1'b0}}, b} : cnt_q != '0 ? {sum, acc_q[WIDTH-1:1]} : acc_q;
      a_d    = start ? a : a_q;
      cnt_d  = start ? CW'(WIDTH) : cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
      done_d = !start && cnt_q == CW'(1);
   end
   // state registers, cleared asynchronously so a reset drops any product in flight
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc_q  <= '0;
         a_q    <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         a_q    <= a_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end
   assign product = acc_q;
   assign done    = done_q;
endmodule

// File: rtl/ula_seq.sv
// ula_seq: multi-cycle ALU with start/busy/done handshake, bit-serial shifts, shift-add multiply and N/Z/C/V flags
module ula_seq
   import ula_pkg::*;
#(
   parameter int WIDTH = 16,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             inicio,
   input  logic [3:0]       select,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] resultado,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V,
   output logic             ocupado,
   output logic             pronto
);
   state_t             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   x_q, x_d, y_q, y_d, res_q, res_d, r;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [3:0]         flg_q, flg_d;
   logic               sc_q, sc_d, ocupado_q, ocupado_d, pronto_q, pronto_d;
   logic               accept, finish, is_shift, is_mul, mul_done, rc, rv;
   logic [WIDTH:0]     add_s, sub_s;
   logic [2*WIDTH-1:0] prod;
   ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clock  (clock),
      .resetn (resetn),
      .start  (accept && (select == OP_MUL || select == OP_MULH)),
      .a      (X),
      .b      (Y),
      .product(prod),
      .done   (mul_done)
   );
   // result and C/V of the latched operation, evaluated in the last EXECUTA cycle
   always_comb begin
      add_s = {1'b0, x_q} + {1'b0, y_q};
      sub_s = {1'b0, x_q} + {1'b0, ~y_q} + {{WIDTH{1'b0}}, 1'b1};
      r     = x_q;
      rc    = 1'b0;
      rv    = 1'b0;
      case (op_q)
         OP_ADD: begin
            r  = add_s[WIDTH-1:0];
            rc = add_s[WIDTH];
            rv = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (add_s[WIDTH-1] != x_q[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            r  = sub_s[WIDTH-1:0];
            rc = sub_s[WIDTH];
            rv = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (sub_s[WIDTH-1] != x_q[WIDTH-1]);
         end
         OP_AND:                 r = x_q & y_q;
         OP_OR:                  r = x_q | y_q;
         OP_NOT:                 r = ~x_q;
         OP_XOR:                 r = x_q ^ y_q;
         OP_SHR, OP_SHL, OP_SAR: rc = sc_q;
         OP_MUL: begin
            r  = prod[WIDTH-1:0];
            rv = |prod[2*WIDTH-1:WIDTH];
         end
         OP_MULH:                r = prod[2*WIDTH-1:WIDTH];
         default:                r = x_q;
      endcase
   end
   // next-state: accept in OCIOSO/FIM, step shifts in EXECUTA, commit result/flags only on completion
   always_comb begin
      is_shift  = op_q == OP_SHR || op_q == OP_SHL || op_q == OP_SAR;
      is_mul    = op_q == OP_MUL || op_q == OP_MULH;
      accept    = inicio && state_q != EXECUTA;
      finish    = state_q == EXECUTA && (is_shift ? cnt_q == '0 : is_mul ? mul_done : 1'b1);
      state_d   = accept ? EXECUTA : finish ? FIM : state_q == FIM ? OCIOSO : state_q;
      ocupado_d = state_d == EXECUTA;
      pronto_d  = state_d == FIM;
      op_d      = accept ? select : op_q;
      y_d       = accept ? Y : y_q;
      x_d       = x_q;
      cnt_d     = cnt_q;
      sc_d      = sc_q;
      res_d     = res_q;
      flg_d     = flg_q;
      if (accept) begin
         x_d   = X;
         cnt_d = Y[SHW-1:0];
         sc_d  = 1'b0;
      end else if (state_q == EXECUTA && is_shift && cnt_q != '0) begin
         x_d   = op_q == OP_SHL ? {x_q[WIDTH-2:0], 1'b0} :
                 {op_q == OP_SAR && x_q[WIDTH-1], x_q[WIDTH-1:1]};
         sc_d  = op_q == OP_SHL ? x_q[WIDTH-1] : x_q[0];
         cnt_d = cnt_q - SHW'(1);
      end
      if (finish) begin
         res_d         = op_q == OP_CMP ? res_q : r;
         flg_d[FLAG_N] = r[WIDTH-1];
         flg_d[FLAG_Z] = r == '0;
         flg_d[FLAG_C] = rc;
         flg_d[FLAG_V] = rv;
      end
   end
   // FSM and datapath registers with registered handshake outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= OCIOSO;
         op_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         cnt_q     <= '0;
         sc_q      <= 1'b0;
         res_q     <= '0;
         flg_q     <= '0;
         ocupado_q <= 1'b0;
         pronto_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         x_q       <= x_d;
         y_q       <= y_d;
         cnt_q     <= cnt_d;
         sc_q      <= sc_d;
         res_q     <= res_d;
         flg_q     <= flg_d;
         ocupado_q <= ocupado_d;
         pronto_q  <= pronto_d;
      end
   end
   assign resultado = res_q;
   assign N         = flg_q[FLAG_N];
   assign Z         = flg_q[FLAG_Z];
   assign C         = flg_q[FLAG_C];
   assign V         = flg_q[FLAG_V];
   assign ocupado   = ocupado_q;
   assign pronto    = pronto_q;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed and random checks of ula_seq against an arithmetic reference model
module tb_ula_seq;
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        inicio = 1'b0;
   logic [3:0]  select = '0;
   logic [15:0] X = '0, Y = '0;
   logic [15:0] resultado;
   logic        N, Z, C, V, ocupado, pronto;
   int          checks = 0, failures = 0;
   logic [15:0] prev_res = '0;
   ula_seq dut (
      .clock(clock), .resetn(resetn), .inicio(inicio), .select(select), .X(X), .Y(Y),
      .resultado(resultado), .N(N), .Z(Z), .C(C), .V(V), .ocupado(ocupado), .pronto(pronto)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // {resultado, N, Z, C, V} from plain arithmetic; prev is the result held across CMP
   function automatic logic [19:0] ref_alu(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y, input logic [15:0] prev);
      logic [15:0] r, shown;
      logic        c, v;
      int          sx, sy, s;
      int unsigned k;
      logic [31:0] p;
      sx = $signed(x);
      sy = $signed(y);
      k  = y % 16;
      p  = x * y;
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         4'h0: begin r = x + y; c = (int'(x) + int'(y)) > 65535; s = sx + sy; v = s > 32767 || s < -32768; end
         4'h1, 4'hC: begin r = x - y; c = x >= y; s = sx - sy; v = s > 32767 || s < -32768; end
         4'h2: r = x & y;
         4'h3: r = x | y;
         4'h4: r = ~x;
         4'h5: begin r = x >> k; c = k != 0 ? x[k-1] : 1'b0; end
         4'h6: begin r = x << k; c = k != 0 ? x[16-k] : 1'b0; end
         4'h8: r = x ^ y;
         4'h9: begin r = $signed(x) >>> k; c = k != 0 ? x[k-1] : 1'b0; end
         4'hA: begin r = p[15:0]; v = p[31:16] != 0; end
         4'hB: r = p[31:16];
         default: r = x;
      endcase
      shown = op == 4'hC ? prev : r;
      return {shown, r[15], r == 16'h0, c, v};
   endfunction
   function automatic int ref_lat(input logic [3:0] op, input logic [15:0] y);
      if (op == 4'h5 || op == 4'h6 || op == 4'h9) return int'(y % 16) + 2;
      if (op == 4'hA || op == 4'hB) return 18;
      return 2;
   endfunction
   // waits for pronto counting cycles since the accept cycle; cycle budget bounds the wait
   task automatic wait_done(output int cyc, output bit stable);
      cyc = 1;
      stable = 1;
      while (!pronto && cyc < 100) begin
         if (resultado !== prev_res) stable = 0;
         @(posedge clock);
         #1;
         cyc++;
      end
   endtask
   task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
      logic [19:0] e;
      int          cyc;
      bit          stable;
      e = ref_alu(op, x, y, prev_res);
      @(negedge clock);
      inicio = 1'b1; select = op; X = x; Y = y;
      @(posedge clock);
      #1;
      inicio = 1'b0;
      chk($sformatf("busy op%h", op), ocupado, 1);
      wait_done(cyc, stable);
      chk($sformatf("latency op%h", op), cyc, ref_lat(op, y));
      chk($sformatf("stable op%h", op), stable, 1);
      chk($sformatf("result op%h x=%h y=%h", op, x, y), resultado, e[19:4]);
      chk($sformatf("flags op%h x=%h y=%h", op, x, y), {N, Z, C, V}, e[3:0]);
      chk($sformatf("idle_at_done op%h", op), ocupado, 0);
      prev_res = e[19:4];
   endtask
   initial begin
      int          cyc;
      bit          stable, got_p;
      logic [19:0] e;
      repeat (3) @(posedge clock);
      #1;
      chk("reset result", resultado, 0);
      chk("reset flags", {N, Z, C, V}, 0);
      chk("reset busy", ocupado, 0);
      chk("reset pronto", pronto, 0);
      @(negedge clock);
      resetn = 1'b1;
      run_op(4'h0, 16'h7FFF, 16'h0001);
      run_op(4'h1, 16'h0005, 16'h0005);
      run_op(4'h9, 16'h8010, 16'h0004);
      run_op(4'h6, 16'h1234, 16'h0000);
      run_op(4'h6, 16'h8001, 16'h0001);
      run_op(4'h5, 16'hF00F, 16'h0013);
      run_op(4'hA, 16'h0123, 16'h0100);
      run_op(4'hB, 16'h0123, 16'h0100);
      run_op(4'hA, 16'hFFFF, 16'hFFFF);
      run_op(4'h0, 16'h1111, 16'h2222);
      run_op(4'hC, 16'h0003, 16'h0007);
      run_op(4'h9, 16'h8000, 16'h000F);
      run_op(4'hE, 16'hBEEF, 16'h1234);
      for (int i = 0; i < 40; i++)
         run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      // inicio held high across a MUL: ignored while busy, accepted again in the FIM cycle
      e = ref_alu(4'hA, 16'h0003, 16'h0005, prev_res);
      @(negedge clock);
      inicio = 1'b1; select = 4'hA; X = 16'h0003; Y = 16'h0005;
      @(posedge clock);
      #1;
      wait_done(cyc, stable);
      chk("held latency", cyc, 18);
      chk("held result", resultado, e[19:4]);
      @(posedge clock);
      #1;
      chk("fim accept busy", ocupado, 1);
      chk("pronto pulse", pronto, 0);
      inicio = 1'b0;
      prev_res = e[19:4];
      wait_done(cyc, stable);
      chk("b2b latency", cyc, 18);
      chk("b2b stable", stable, 1);
      chk("b2b result", resultado, e[19:4]);
      run_op(4'h0, 16'h0F0F, 16'h0101);
      // asynchronous reset in the middle of a MUL
      @(negedge clock);
      inicio = 1'b1; select = 4'hA; X = 16'hFFFF; Y = 16'hFFFF;
      @(posedge clock);
      #1;
      inicio = 1'b0;
      repeat (5) @(posedge clock);
      #3;
      resetn = 1'b0;
      #1;
      chk("async result", resultado, 0);
      chk("async flags", {N, Z, C, V}, 0);
      chk("async busy", ocupado, 0);
      got_p = 0;
      repeat (4) begin
         @(posedge clock);
         #1;
         got_p |= pronto;
      end
      @(negedge clock);
      resetn = 1'b1;
      repeat (25) begin
         @(posedge clock);
         #1;
         got_p |= pronto | ocupado;
      end
      chk("no pronto after reset", got_p, 0);
      prev_res = '0;
      run_op(4'h0, 16'h8000, 16'h8000);
      run_op(4'hA, 16'h00FF, 16'h0101);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
